fetch_sched: RTL

Instruction-fetch scheduler that owns the program counter and sequences requests to the instruction cache. It arbitrates three PC sources (exception redirect, branch redirect, sequential +4), issues fetch requests over a valid/ready handshake, and tracks up to `MAX_OUTSTANDING` in-flight requests. It pairs each response with its PC and discards responses made stale by a redirect. It sits between the execute/CSR redirect logic and the IF/ID pipeline register, and replaces the free-running PC register.

---
 rtl/fetch_sched_pkg.sv | 18 +
 rtl/fetch_tag_fifo.sv | 47 ++++
 rtl/fetch_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_sched_pkg.sv
// Shared types and constants for the instruction-fetch scheduler.
package fetch_sched_pkg;

  localparam int unsigned InstAddrWidth = 32;
  localparam logic [InstAddrWidth-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Clears the byte-offset bits so a redirect always lands on a word.
  function automatic logic [InstAddrWidth-1:0] align_pc(input logic [InstAddrWidth-1:0] pc);
    return pc & ~InstAddrWidth'(3);
  endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// Synchronous first-word-fall-through FIFO holding the PC of every accepted fetch.
module fetch_tag_fifo
  import fetch_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = InstAddrWidth
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fetch_sched.sv
// Instruction-fetch scheduler: owns the PC, issues cache requests, pairs responses with PCs.
// Optional misaligned-redirect trap enabled by defining FETCH_ADEF_CHECK_EN (adds adef_o).
module fetch_sched
  import fetch_sched_pkg::*;
#(
  parameter logic [InstAddrWidth-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned              MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               pause_i,
  input  logic                     excp_en_i,
  input  logic [InstAddrWidth-1:0] excp_pc_i,
  input  logic                     branch_en_i,
  input  logic [InstAddrWidth-1:0] branch_target_i,
  output logic                     inst_req_o,
  output logic [InstAddrWidth-1:0] inst_addr_o,
  input  logic                     inst_ready_i,
  input  logic                     inst_rvalid_i,
  input  logic [31:0]              inst_rdata_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [InstAddrWidth-1:0] inst_pc_o,
`ifdef FETCH_ADEF_CHECK_EN
  output logic                     adef_o,
`endif
  output logic [1:0]               dbg_state_o
);

  // Handshake: a request transfers in any cycle where inst_req_o and inst_ready_i are
  // both high; the address may change freely while inst_ready_i is low. Responses are
  // single-cycle inst_rvalid_i pulses returned in request order, with no back-pressure.

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  fetch_state_e               state_q, state_d;
  logic [InstAddrWidth-1:0]   pc_q, pc_d;
  logic                       req_q, req_d;
  logic [CntW-1:0]            out_cnt_q, out_cnt_d;
  logic [CntW-1:0]            drop_cnt_q, drop_cnt_d;
  logic                       valid_q, valid_d;
  logic [31:0]                inst_q, inst_d;
  logic [InstAddrWidth-1:0]   ipc_q, ipc_d;
  logic                       adef_q, adef_d;

  logic                       accept, rsp, redirect, hold;
  logic [InstAddrWidth-1:0]   redir_raw, redir_pc, tag;
  logic                       fifo_empty;
  logic                       unused_fifo_full;
  logic                       unused_pause;

  assign unused_pause = ^pause_i[5:1];

  assign accept    = req_q && inst_ready_i;
  assign rsp       = inst_rvalid_i && !fifo_empty;
  assign redirect  = excp_en_i || branch_en_i;
  assign redir_raw = excp_en_i ? excp_pc_i : branch_target_i;

`ifdef FETCH_ADEF_CHECK_EN
  assign redir_pc = redir_raw;
  always_comb begin
    adef_d = adef_q;
    if (redirect) adef_d = (redir_raw[1:0] != 2'b00);
  end
  assign adef_o = adef_q;
`else
  assign redir_pc = align_pc(redir_raw);
  assign adef_d   = 1'b0;
`endif

  fetch_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (InstAddrWidth)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (rsp),
    .data_o  (tag),
    .empty_o (fifo_empty),
    .full_o  (unused_fifo_full)
  );

  // Datapath: PC, credit/drop accounting and IF/ID outputs.
  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + (accept ? CntOne : '0) - (rsp ? CntOne : '0);
    drop_cnt_d = drop_cnt_q;
    valid_d    = rsp && (drop_cnt_q == '0);
    inst_d     = inst_q;
    ipc_d      = ipc_q;

    if (redirect)    pc_d = redir_pc;
    else if (accept) pc_d = pc_q + InstAddrWidth'(4);

    // Everything still in flight after this edge, including this cycle's accept, is stale.
    if (redirect)                        drop_cnt_d = out_cnt_d;
    else if (rsp && drop_cnt_q != '0)    drop_cnt_d = drop_cnt_q - CntOne;

    if (valid_d) begin
      inst_d = inst_rdata_i;
      ipc_d  = tag;
    end
  end

  assign hold = pause_i[0] || (out_cnt_d == CntMax) || adef_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: state_d = adef_d ? FETCH_HOLD : FETCH_RUN;
      FETCH_RUN:  if (hold)  state_d = FETCH_HOLD;
      FETCH_HOLD: if (!hold) state_d = FETCH_RUN;
      default:    state_d = FETCH_IDLE;
    endcase
    req_d = (state_d == FETCH_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      ipc_q      <= '0;
      adef_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      adef_q     <= adef_d;
    end
  end

  assign inst_req_o   = req_q;
  assign inst_addr_o  = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = ipc_q;
  assign dbg_state_o  = state_q;

endmodule
